// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Word-organised data RAM for the load/store stage of the pipelined MIPS CPU.
// Four byte-wide lane memories hold the stored words, so a store can update any
// combination of byte lanes. Writes happen on the rising clock edge. Reads are
// combinational and always return the full 32-bit word. The CPU's read-mask
// logic picks out bytes and halfwords.
//
// Optional feature macro: DATA_MEMORY_RANGE_CHECK_EN
//   When this macro is defined, any nonzero address bit above INDEX_WIDTH+1
//   marks the access as out of range. Such writes are dropped and such reads
//   return 0.
//   When it is undefined, the upper address bits are ignored and accesses wrap
//   modulo DEPTH_WORDS.
//
// Parameters:
//   ADDR_WIDTH   - byte address width
//   DEPTH_WORDS  - number of 32-bit words (power of two)
//   INDEX_WIDTH  - word index width, log2(DEPTH_WORDS)
//
// Ports:
//   clk        in   system clock; writes on the rising edge
//   rst        in   asynchronous active-high reset; forces data_o to 0 and
//                   blocks writes. Stored contents are kept.
//   ce         in   read enable
//   we         in   write enable (not gated by ce)
//   addr_i     in   byte address; bits [1:0] are ignored
//   byte_slct  in   byte-lane enables; bit k selects data bits [8k+7:8k]
//   data_i     in   write data
//   data_o     out  read data; 0 when ce=0 or rst=1
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int INDEX_WIDTH = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            byte_slct,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o
);

    logic [INDEX_WIDTH-1:0] w_index;
    logic                   w_in_range;
    logic [7:0]             w_lane_rd [4];
    logic [31:0]            w_rd_word;

    assign w_index = addr_i[INDEX_WIDTH+1:2];

`ifdef DATA_MEMORY_RANGE_CHECK_EN
    generate
        if (ADDR_WIDTH > INDEX_WIDTH + 2) begin : g_range
            assign w_in_range = ~|addr_i[ADDR_WIDTH-1:INDEX_WIDTH+2];
        end else begin : g_no_range
            // The address bus cannot reach past the array.
            assign w_in_range = 1'b1;
        end
    endgenerate
`else
    assign w_in_range = 1'b1;
`endif

    // Each byte lane is a separate memory. Only that lane's write enable
    // touches it, so unselected lanes keep their contents.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [DEPTH_WORDS] = '{default: 8'h00};

            // Only the clock appears here because reset never clears the
            // stored contents. The rst term blocks a write on any edge where
            // reset is asserted.
            always_ff @(posedge clk) begin
                if (!rst && we && byte_slct[gi] && w_in_range) begin
                    r_lane[w_index] <= data_i[8*gi +: 8];
                end
            end

            assign w_lane_rd[gi] = r_lane[w_index];
        end
    endgenerate

    assign w_rd_word = {w_lane_rd[3], w_lane_rd[2], w_lane_rd[1], w_lane_rd[0]};

    // The read path is purely combinational, so rst forces the output low
    // immediately, with no clock edge needed.
    assign data_o = (ce && !rst && w_in_range) ? w_rd_word : 32'h0000_0000;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr_i;
    logic [3:0]  byte_slct;
    logic [31:0] data_i;
    logic [31:0] data_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    data_memory #(
        .ADDR_WIDTH (32),
        .DEPTH_WORDS(1024)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .we       (we),
        .addr_i   (addr_i),
        .byte_slct(byte_slct),
        .data_i   (data_i),
        .data_o   (data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare data_o against the oldest queued expectation.
    task automatic check_out();
        logic [31:0] exp;
        string       tag;
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        n_tests++;
        assert (data_o === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, data_o, exp);
        end
        $display("[TB] %s addr=%h observed=%h expected=%h", tag, addr_i, data_o, exp);
    endtask

    task automatic expect_now(input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        check_out();
    endtask

    task automatic do_read(input logic [31:0] a, input logic c,
                           input logic [3:0] s, input logic [31:0] exp,
                           input string tag);
        @(negedge clk);
        we        = 1'b0;
        ce        = c;
        addr_i    = a;
        byte_slct = s;
        expect_now(exp, tag);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic c);
        @(negedge clk);
        we        = 1'b1;
        ce        = c;
        addr_i    = a;
        data_i    = d;
        byte_slct = s;
        @(posedge clk);
        #1;
        we = 1'b0;
        $display("[TB] write addr=%h data=%h slct=%b ce=%b", a, d, s, c);
    endtask

    logic [31:0] model [8];
    int          idx;
    logic [31:0] d;
    logic [3:0]  s;

    initial begin
        rst       = 1'b1;
        ce        = 1'b1;
        we        = 1'b0;
        addr_i    = 32'h10;
        byte_slct = 4'hF;
        data_i    = 32'h0;

        // The output is held at 0 while reset is asserted.
        expect_now(32'h0, "reset_out");
        @(posedge clk);
        #1;
        expect_now(32'h0, "reset_out_after_edge");
        @(negedge clk);
        rst = 1'b0;
        do_read(32'h0, 1'b1, 4'hF, 32'h0, "powerup_word0");

        // Full-word write, then read with ce high and ce low.
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        do_read(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, "full_word");
        do_read(32'h10, 1'b0, 4'hF, 32'h0, "ce_low");

        // Byte-lane writes.
        do_write(32'h10, 32'h00000055, 4'b0001, 1'b1);
        do_read(32'h10, 1'b1, 4'hF, 32'hDEADBE55, "lane0");
        do_write(32'h10, 32'h12340000, 4'b1100, 1'b1);
        do_read(32'h10, 1'b1, 4'b0000, 32'h1234BE55, "lane32_slct_ignored_on_read");
        do_write(32'h10, 32'hFFFFFFFF, 4'b0000, 1'b1);
        do_read(32'h10, 1'b1, 4'hF, 32'h1234BE55, "slct_zero_no_write");

        // Misaligned address with ce low still writes the aligned word.
        do_write(32'h23, 32'hCAFEF00D, 4'hF, 1'b0);
        do_read(32'h20, 1'b1, 4'hF, 32'hCAFEF00D, "align_ce_indep");

        // Same-cycle read and write: the old word shows before the edge and
        // the merged word shows after it.
        @(negedge clk);
        we = 1'b1; ce = 1'b1; addr_i = 32'h30; data_i = 32'hAAAA5555; byte_slct = 4'b0110;
        expect_now(32'h0, "rw_before_edge");
        @(posedge clk);
        #1;
        expect_now(32'h00AA5500, "rw_after_edge");
        we = 1'b0;

        // Reset asserted during a write edge: the output drops at once and
        // the write is discarded.
        @(negedge clk);
        ce = 1'b1; addr_i = 32'h10; byte_slct = 4'hF; data_i = 32'hFFFFFFFF; we = 1'b1;
        expect_now(32'h1234BE55, "pre_reset_read");
        rst = 1'b1;
        expect_now(32'h0, "async_reset_out");
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expect_now(32'h1234BE55, "reset_mid_write_kept");

        // Out-of-range behaviour.
        do_write(32'h1000, 32'hA5A5A5A5, 4'hF, 1'b1);
`ifdef DATA_MEMORY_RANGE_CHECK_EN
        do_read(32'h0, 1'b1, 4'hF, 32'h0, "range_wrap_blocked");
        do_read(32'h1000, 1'b1, 4'hF, 32'h0, "range_read_zero");
`else
        do_read(32'h0, 1'b1, 4'hF, 32'hA5A5A5A5, "range_wrap");
        do_read(32'h1000, 1'b1, 4'hF, 32'hA5A5A5A5, "range_alias_read");
`endif

        // Random lane writes to words 64..71, checked against a lane-merge model.
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        for (int t = 0; t < 16; t++) begin
            idx = $urandom_range(0, 7);
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            do_write(32'h100 + 32'(idx * 4), d, s, 1'($urandom_range(0, 1)));
            for (int k = 0; k < 4; k++) begin
                if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
            end
            do_read(32'h100 + 32'(idx * 4), 1'b1, 4'hF, model[idx], "rand_lane");
        end
        for (int i = 0; i < 8; i++) begin
            do_read(32'h100 + 32'(i * 4), 1'b1, 4'($urandom_range(0, 15)), model[i], "rand_final");
        end

        // These earlier words must not have been disturbed.
        do_read(32'h10, 1'b1, 4'hF, 32'h1234BE55, "final_0x10");
        do_read(32'h20, 1'b1, 4'hF, 32'hCAFEF00D, "final_0x20");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data RAM with per-byte write lanes that serves the load/store stage of the pipelined MIPS CPU in the SOPC test system. It takes a byte address, a 4-bit byte-lane select and a write enable from the CPU's MEM stage. Writes are synchronous. Reads are combinational and always return a full 32-bit word; the CPU's read-mask logic extracts bytes and halfwords.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: width of the byte address bus `addr_i`.
- `DEPTH_WORDS`, default 1024: number of 32-bit words stored; must be a power of two.
- `INDEX_WIDTH`, default log2(`DEPTH_WORDS`) = 10: word-index width.

Ports:
- `clk` in, 1: single system clock; all writes occur on its rising edge.
- `rst` in, 1: reset, asynchronous and active-high.
- `ce` in, 1: read enable (driven by the CPU's `mem_re`).
- `we` in, 1: write enable.
- `addr_i` in, `ADDR_WIDTH`: byte address.
- `byte_slct` in, 4: byte-lane enables.
- `data_i` in, 32: write data.
- `data_o` out, 32: read data.

## Operation
- Storage is `DEPTH_WORDS` × 32-bit words.
- Word index = `addr_i[INDEX_WIDTH+1:2]`. `addr_i[1:0]` is ignored, so accesses are word-aligned.
- Lane mapping: `byte_slct[k]` controls bits `[8k+7:8k]`. Bit 3 is `[31:24]` and bit 0 is `[7:0]`.
- Write: on a rising `clk` with `we`=1 and `rst`=0, each lane whose `byte_slct` bit is 1 takes the matching byte of `data_i`. Unselected lanes keep their contents.
- Writes depend on `we` only; `ce` does not gate writes.
- `we`=1 with `byte_slct`=0000 changes nothing.
- Read: `data_o` = full stored word at the index when `ce`=1 and `rst`=0. Otherwise `data_o` = 0.
- `byte_slct` has no effect on reads.
- Reset:
  - While `rst`=1, `data_o` is forced to 0 immediately, independent of the clock, and all writes are blocked.
  - Stored contents are not cleared by reset.
  - Power-up contents are 0.
- Reset asserted mid-operation: a write whose edge coincides with `rst`=1 is dropped. The output recovers combinationally when `rst` falls.

## Timing
- Write latency: 1 clock edge. Data written at edge N is visible on `data_o` immediately after edge N.
- Read latency: 0 cycles, purely combinational from `addr_i`, `ce` and `rst`.
- Read and write to the same word in the same cycle: `data_o` shows the old word before the edge and the merged new word after the edge.
- There is no handshake and no stall; every access completes in the cycle it is presented.

## Configuration
- Macro: `DATA_MEMORY_RANGE_CHECK_EN`.
- Defined:
  - An address is out of range when any bit of `addr_i` above `INDEX_WIDTH+1` is nonzero, i.e. byte address ≥ 4×`DEPTH_WORDS`.
  - Out-of-range writes are discarded.
  - Out-of-range reads return 0.
- Undefined: upper address bits are ignored and accesses wrap modulo `DEPTH_WORDS`.

## Test plan
- Reset: hold `rst`=1 with `ce`=1 at any address -> `data_o`=0x00000000. Release `rst`; reading word 0 returns 0x00000000.
- Full-word write then read:
  - Write 0xDEADBEEF to addr 0x10 with `byte_slct`=1111, then `ce`=1 at 0x10 -> `data_o`=0xDEADBEEF.
  - With `ce`=0 -> `data_o`=0.
- Byte lanes:
  - Starting from 0xDEADBEEF at 0x10, write 0x00000055 with `byte_slct`=0001 -> 0xDEADBE55.
  - Then write 0x12340000 with `byte_slct`=1100 -> 0x1234BE55.
- Alignment and `ce` independence:
  - Write 0xCAFEF00D at 0x23 with `ce`=0 and `we`=1 -> reading 0x20 returns 0xCAFEF00D.
- Reset mid-write:
  - Assert `rst` during an edge with `we`=1 and data 0xFFFFFFFF at 0x10 -> after release, 0x10 still holds 0x1234BE55.
- Range:
  - Write 0xA5A5A5A5 at byte address 0x1000 (`DEPTH_WORDS`=1024).
  - Without the macro -> reading 0x0 returns 0xA5A5A5A5.
  - With `DATA_MEMORY_RANGE_CHECK_EN` -> reading 0x0 returns its prior value and reading 0x1000 returns 0.
